button_cmd_scheduler: RTL and testbench

//  Collects one-cycle press ticks from N button_tick_latch instances, plus raw button levels, and keeps
//  one pending event per button. Generates auto-repeat events for buttons held down. Grants pending

---
 rtl/button_cmd_scheduler.sv | 177 +++++++++++++++++
 tb/tb_button_cmd_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_scheduler.sv
// ============================================================================
// Module      : button_cmd_scheduler
// Description : Per-button pending events with auto-repeat, round-robin grant,
//               one command at a time on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_cmd_scheduler #(
    parameter int N_BTN         = 4,
    parameter int ID_W          = 2,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_EN,
    input  logic [N_BTN-1:0] i_TICK,
    input  logic [N_BTN-1:0] i_LEVEL,
    output logic             o_CMD_VALID,
    output logic [ID_W-1:0]  o_CMD_ID,
    output logic             o_CMD_REPEAT,
    input  logic             i_CMD_READY,
    output logic             o_OVERRUN
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    logic [N_BTN-1:0] w_rep_evt;
    logic [N_BTN-1:0] w_evt;
    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] w_pending_nxt;
    logic [N_BTN-1:0] r_rep_flag;
    logic [N_BTN-1:0] w_rep_flag_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [ID_W-1:0]  w_gnt;
    logic [ID_W:0]    w_sum;
    logic             w_found;
    logic             w_slot_free;
    logic             w_grant;
    logic             w_overrun_nxt;

    // Per-button hold/auto-repeat state machine
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_rep;

        always_ff @(posedge i_CLK or negedge i_RST_N) begin
            if (!i_RST_N) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rep       = 1'b0;
            if (!i_LEVEL[gi] || !i_EN) begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        w_state_nxt = c_ST_HOLD;
                        w_cnt_nxt   = '0;
                    end
                    c_ST_HOLD: begin
                        if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                            w_rep       = 1'b1;
                            w_state_nxt = c_ST_REPEAT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    c_ST_REPEAT: begin
                        if (r_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
                            w_rep     = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        assign w_rep_evt[gi] = w_rep;
    end

    assign w_evt       = {N_BTN{i_EN}} & (i_TICK | w_rep_evt);
    assign w_slot_free = ~o_CMD_VALID | i_CMD_READY;
    assign w_grant     = w_slot_free & i_EN & w_found;

    // Round-robin search starting at the pointer, wrapping at N_BTN
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        for (int k = 0; k < N_BTN; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_BTN)) begin
                w_sum = w_sum - (ID_W+1)'(N_BTN);
            end
            if (!w_found && r_pending[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == ID_W'(N_BTN - 1)) ? '0 : w_gnt + ID_W'(1);

    // A new event wins over the grant clear, so a same-cycle event is kept
    always_comb begin
        w_pending_nxt  = r_pending;
        w_rep_flag_nxt = r_rep_flag;
        w_overrun_nxt  = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!i_EN) begin
                w_pending_nxt[i] = 1'b0;
            end else if (w_evt[i]) begin
                w_pending_nxt[i]  = 1'b1;
                w_rep_flag_nxt[i] = w_rep_evt[i] & ~i_TICK[i];
                if (r_pending[i] && !(w_grant && (w_gnt == ID_W'(i)))) begin
                    w_overrun_nxt = 1'b1;
                end
            end else if (w_grant && (w_gnt == ID_W'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_pending    <= '0;
            r_rep_flag   <= '0;
            r_ptr        <= '0;
            o_CMD_VALID  <= 1'b0;
            o_CMD_ID     <= '0;
            o_CMD_REPEAT <= 1'b0;
            o_OVERRUN    <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_rep_flag <= w_rep_flag_nxt;
            o_OVERRUN  <= w_overrun_nxt;
            if (w_slot_free) begin
                if (w_grant) begin
                    o_CMD_VALID  <= 1'b1;
                    o_CMD_ID     <= w_gnt;
                    o_CMD_REPEAT <= r_rep_flag[w_gnt];
                    r_ptr        <= w_ptr_nxt;
                end else begin
                    o_CMD_VALID <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_cmd_scheduler.sv
// ============================================================================
// Module      : tb_button_cmd_scheduler
// Description : Scoreboard bench for button_cmd_scheduler (HOLD=8, REPEAT=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_cmd_scheduler;

    localparam int N_BTN = 4;
    localparam int ID_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N_BTN-1:0] tick;
    logic [N_BTN-1:0] level;
    logic             ready;
    logic             valid;
    logic [ID_W-1:0]  id;
    logic             rep;
    logic             overrun;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            rep;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    button_cmd_scheduler #(
        .N_BTN(N_BTN), .ID_W(ID_W), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)
    ) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_EN(en), .i_TICK(tick), .i_LEVEL(level),
        .o_CMD_VALID(valid), .o_CMD_ID(id), .o_CMD_REPEAT(rep),
        .i_CMD_READY(ready), .o_OVERRUN(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input logic r);
        exp_t e;
        e.id  = ID_W'(b);
        e.rep = r;
        q.push_back(e);
    endtask

    // Scoreboard monitor: every accepted command must match the queue head
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd actual id=%0d rep=%0d required none at %0t", id, rep, $time);
            end else begin
                m_e = q.pop_front();
                chk("cmd_id", 32'(id), 32'(m_e.id));
                chk("cmd_repeat", 32'(rep), 32'(m_e.rep));
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; tick = '0; level = '0; ready = 1'b1;

        // T1: reset with toggling inputs
        for (int i = 0; i < 4; i++) begin
            tick  = 4'($urandom);
            level = 4'($urandom);
            step();
            chk("rst_valid", 32'(valid), 0);
            chk("rst_id", 32'(id), 0);
            chk("rst_repeat", 32'(rep), 0);
            chk("rst_overrun", 32'(overrun), 0);
        end
        tick = '0; level = '0;
        step();
        rst_n = 1'b1;
        step();
        tick = 4'b0100; push(2, 1'b0);
        step();
        tick = '0;
        chk("t1_lat_k1", 32'(valid), 0);
        step();
        chk("t1_lat_k2", 32'(valid), 1);
        chk("t1_id", 32'(id), 2);
        step(); step();

        // T2: round-robin from a fresh pointer
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        tick = 4'b1011; push(0, 1'b0); push(1, 1'b0); push(3, 1'b0);
        step();
        tick = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_b2b_valid", 32'(valid), 1);
        end
        step();
        chk("t2_idle", 32'(valid), 0);
        tick = 4'b1001; push(0, 1'b0); push(3, 1'b0);
        step();
        tick = '0;
        step();
        chk("t2_wrap_id", 32'(id), 0);
        step(); step(); step();

        // T3: backpressure, coalescing and overrun
        ready = 1'b0;
        tick = 4'b0010; push(1, 1'b0);
        step(); tick = '0; step();
        chk("t3_valid", 32'(valid), 1);
        tick = 4'b0010; push(1, 1'b0);
        step(); tick = '0;
        chk("t3_no_overrun", 32'(overrun), 0);
        tick = 4'b0010;
        step(); tick = '0;
        chk("t3_overrun", 32'(overrun), 1);
        step();
        chk("t3_overrun_pulse", 32'(overrun), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_valid", 32'(valid), 1);
            chk("t3_hold_id", 32'(id), 1);
            chk("t3_hold_rep", 32'(rep), 0);
        end
        ready = 1'b1;
        step(); step(); step(); step();
        chk("t3_drained", 32'(valid), 0);

        // T4: auto-repeat on button 1; repeat events at hold cycles 8,12,16,20
        for (int i = 0; i < 4; i++) push(1, 1'b1);
        level = 4'b0010;
        for (int n = 1; n <= 21; n++) begin
            step();
            if (n == 9)  chk("t4_first_early", 32'(valid), 0);
            if (n == 10) chk("t4_first_valid", 32'(valid), 1);
            if (n == 10) chk("t4_first_rep", 32'(rep), 1);
        end
        level = '0;
        for (int i = 0; i < 12; i++) step();
        chk("t4_queue_empty", 32'(q.size()), 0);

        // T5: tick on the button granted in the same cycle
        tick = 4'b0001; push(0, 1'b0);
        step();
        push(0, 1'b0);
        step();
        tick = '0;
        chk("t5_no_overrun", 32'(overrun), 0);
        step();
        chk("t5_second_valid", 32'(valid), 1);
        chk("t5_second_id", 32'(id), 0);
        step(); step();
        // i_EN low with pending: held command completes, pending dropped
        ready = 1'b0;
        tick = 4'b0100; push(2, 1'b0);
        step(); tick = '0; step();
        chk("t5_held_id", 32'(id), 2);
        tick = 4'b1000;
        step(); tick = '0;
        en = 1'b0; ready = 1'b1;
        step();
        chk("t5_en_accept", 32'(valid), 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_pending_dropped", 32'(valid), 0);
        end

        // T6: reset mid-handshake
        ready = 1'b0;
        tick = 4'b0010;
        step(); tick = '0; step();
        chk("t6_valid_before", 32'(valid), 1);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_drop", 32'(valid), 0);
        step(); step();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_cmd", 32'(valid), 0);
        end
        tick = 4'b1000; push(3, 1'b0);
        step(); tick = '0;
        step(); step(); step();
        chk("final_queue_empty", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
